// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide
// over 32 RUN cycles on operand magnitudes, with the sign fix-up applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic             sign_a;
  logic             sign_b;
  // opnd holds |a| for multiply (multiplicand) and |b| for divide (divisor);
  // work_lo starts as the other operand and ends as product low / quotient.
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  logic             is_div;
  logic             is_signed;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x,
                                                   input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_negate_wide(input logic [2*WIDTH-1:0] x,
                                                          input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];

  always_comb begin
    mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shifted = {work_hi, work_lo[WIDTH-1]};
    div_ge      = div_shifted >= {1'b0, opnd};
    // When div_ge holds the true difference is below opnd, so WIDTH bits suffice.
    div_diff    = div_shifted[WIDTH-1:0] - opnd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_r    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= '0;
            op_r    <= op;
            sign_a  <= ~op[0] & a[WIDTH-1];
            sign_b  <= ~op[0] & b[WIDTH-1];
            work_hi <= '0;
            if (op[1]) begin
              opnd    <= cond_negate(b, ~op[0] & b[WIDTH-1]);
              work_lo <= cond_negate(a, ~op[0] & a[WIDTH-1]);
            end else begin
              opnd    <= cond_negate(a, ~op[0] & a[WIDTH-1]);
              work_lo <= cond_negate(b, ~op[0] & b[WIDTH-1]);
            end
          end
        end
        RUN: begin
          if (is_div) begin
            work_hi <= div_ge ? div_diff : div_shifted[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], div_ge};
          end else begin
            work_hi <= mul_sum[WIDTH:1];
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          // Divide by zero leaves remainder = |a|; the sign fix-up restores a itself.
          if (is_div) begin
            lo <= (opnd == '0) ? '1
                               : cond_negate(work_lo, is_signed & (sign_a ^ sign_b));
            hi <= cond_negate(work_hi, is_signed & sign_a);
          end else begin
            {hi, lo} <= cond_negate_wide({work_hi, work_lo},
                                         is_signed & (sign_a ^ sign_b));
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO from a plain-arithmetic model,
// checked by an independent monitor on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int ops_issued = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference: HI/LO as the architecture defines them, from 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] r;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    r = '0;
    case (o)
      2'd0: r = sx * sy;
      2'd1: r = ux * uy;
      2'd2: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          r = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%h required=none", {hi, lo});
        end else begin
          check("result_hi_lo", {hi, lo}, exp_q.pop_front());
        end
      end
      if (done && busy) begin
        checks++;
        errors++;
        $display("FAIL done_busy_overlap actual=1 required=0");
      end
    end
  end

  // Called at a negedge with the unit idle; launches at the next posedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int poke_start, input int poke_mtlo);
    int n;
    logic [31:0] lo_before;
    lo_before = '0;
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    ops_issued++;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    n = 0;
    while (busy && n < 60) begin
      n++;
      start = (n == poke_start);
      if (poke_mtlo > 0 && n == poke_mtlo + 1) check("mtlo_in_run", lo, lo_before);
      if (n == poke_mtlo) begin
        mtlo = 1'b1;
        wdata = $urandom;
        lo_before = lo;
      end else begin
        mtlo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mtlo = 1'b0;
    check("busy_cycles", n, 33);
    check("done_after_busy", done, 1);
  endtask

  initial begin
    int dc;
    logic [31:0] lo_keep;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'd0, 32'hFFFFFFF9, 32'd6, 0, 0);
    check("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 10, 0);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd3, 32'd100, 32'd7, 0, 5);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd3, 32'd123, 32'd0, 0, 0);
    check("divu_by_zero", {hi, lo}, {32'd123, 32'hFFFFFFFF});
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div_overflow", {hi, lo}, {32'h0, 32'h80000000});
    run_op(2'd2, 32'hFFFFFFF0, 32'd0, 0, 0);

    lo_keep = lo;
    mthi = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", hi, 32'hDEADBEEF);
    check("mthi_keeps_lo", lo, lo_keep);

    op = 2'd2; a = $urandom; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dc = done_count;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", done_count, dc);

    run_op(2'd0, 32'd12345, 32'hFFFFFF00, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);
    end
    repeat (3) @(negedge clk);
    check("done_pulse_count", done_count, ops_issued);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
